// File: rtl/jtpinpon_objscan_if.sv
// Bundle of signals between the object scanner, the object RAM and the object line drawer.
// The scanner takes the master modport; the RAM/drawer side takes the slave modport.
interface jtpinpon_objscan_if #(
   parameter int AW = 7
);
   logic          hinit_x;
   logic [7:0]    vrender;
   logic [AW-1:0] obj_addr;
   logic [7:0]    obj_dout;
   logic          draw;
   logic          busy;
   logic [7:0]    xpos;
   logic [3:0]    ysub;
   logic [4:0]    pal;
   logic          hflip;
   logic          vflip;
   logic [7:0]    code;
   logic          done;
   logic          overflow;

   modport master (
      input  hinit_x, vrender, obj_dout, busy,
      output obj_addr, draw, xpos, ysub, pal, hflip, vflip, code, done, overflow
   );

   modport slave (
      output hinit_x, vrender, obj_dout, busy,
      input  obj_addr, draw, xpos, ysub, pal, hflip, vflip, code, done, overflow
   );
endinterface

// File: rtl/jtpinpon_objscan.sv
// Object-table scanner: on every line start it walks object RAM from the last slot down to 0 and
// hands each object crossing the next line to the object drawer. Define JTPINPON_OBJSCAN_LIMIT_EN
// to cap the number of draws per line at MAX_LINE and flag overflow.
module jtpinpon_objscan #(
   parameter int         OBJ_CNT  = 32,
   parameter logic [7:0] YOFFSET  = 8'd16,
   parameter int         MAX_LINE = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               cen2_i,
   jtpinpon_objscan_if.master bus
);
   localparam int IW = $clog2(OBJ_CNT);
   localparam int AW = IW + 2;

   typedef enum logic [2:0] {IDLE, READ, CHECK, DRAW, WAIT, NEXT} state_t;

   if (MAX_LINE < 1) begin : gBadMaxLine
      $error("jtpinpon_objscan: MAX_LINE must be at least 1");
   end

   state_t        state_q, state_d;
   logic [IW-1:0] index_q, index_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW-1:0] objAddr_q, objAddr_d;
   logic [7:0]    yByte_q, yByte_d;
   logic [7:0]    codeByte_q, codeByte_d;
   logic [7:0]    attrByte_q, attrByte_d;
   logic [7:0]    xByte_q, xByte_d;
   logic          draw_q, draw_d;
   logic [7:0]    xpos_q, xpos_d;
   logic [3:0]    ysub_q, ysub_d;
   logic [4:0]    pal_q, pal_d;
   logic          hflip_q, hflip_d;
   logic          vflip_q, vflip_d;
   logic [7:0]    code_q, code_d;
   logic          done_q, done_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    dy;
   logic          hit;
   logic          limitReached;

   // A slot with Y==0 is empty; otherwise the object covers 16 lines starting at its Y.
   assign dy  = bus.vrender + YOFFSET - yByte_q;
   assign hit = (dy[7:4] == 4'd0) && (yByte_q != 8'd0);

`ifdef JTPINPON_OBJSCAN_LIMIT_EN
   localparam int CW = $clog2(MAX_LINE + 1);
   logic [CW-1:0] hitCnt_q, hitCnt_d;

   assign limitReached = (hitCnt_q == CW'(MAX_LINE));

   // Counts draws the drawer has accepted on the current line.
   always_comb begin
      hitCnt_d = hitCnt_q;
      if (bus.hinit_x)
         hitCnt_d = '0;
      else if (state_q == DRAW && bus.busy)
         hitCnt_d = hitCnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hitCnt_q <= '0;
      else if (cen2_i)
         hitCnt_q <= hitCnt_d;
   end
`else
   assign limitReached = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         index_q    <= IW'(OBJ_CNT - 1);
         cnt_q      <= '0;
         objAddr_q  <= '0;
         yByte_q    <= '0;
         codeByte_q <= '0;
         attrByte_q <= '0;
         xByte_q    <= '0;
         draw_q     <= 1'b0;
         xpos_q     <= '0;
         ysub_q     <= '0;
         pal_q      <= '0;
         hflip_q    <= 1'b0;
         vflip_q    <= 1'b0;
         code_q     <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (cen2_i) begin
         state_q    <= state_d;
         index_q    <= index_d;
         cnt_q      <= cnt_d;
         objAddr_q  <= objAddr_d;
         yByte_q    <= yByte_d;
         codeByte_q <= codeByte_d;
         attrByte_q <= attrByte_d;
         xByte_q    <= xByte_d;
         draw_q     <= draw_d;
         xpos_q     <= xpos_d;
         ysub_q     <= ysub_d;
         pal_q      <= pal_d;
         hflip_q    <= hflip_d;
         vflip_q    <= vflip_d;
         code_q     <= code_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
      end
   end

   // A hit found while the drawer is still busy (e.g. after a restart) waits in CHECK.
   always_comb begin
      state_d = state_q;
      if (bus.hinit_x) begin
         state_d = READ;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            READ:    if (cnt_q == 3'd4) state_d = CHECK;
            CHECK:   if (!hit || limitReached) state_d = NEXT;
                     else if (!bus.busy) state_d = DRAW;
            DRAW:    if (bus.busy) state_d = WAIT;
            WAIT:    if (!bus.busy) state_d = NEXT;
            NEXT:    state_d = (index_q == '0) ? IDLE : READ;
            default: state_d = IDLE;
         endcase
      end
   end

   // RAM reads are pipelined: the address for byte n+1 goes out on the edge that latches byte n-1.
   always_comb begin
      index_d    = index_q;
      cnt_d      = cnt_q;
      objAddr_d  = objAddr_q;
      yByte_d    = yByte_q;
      codeByte_d = codeByte_q;
      attrByte_d = attrByte_q;
      xByte_d    = xByte_q;
      draw_d     = draw_q;
      xpos_d     = xpos_q;
      ysub_d     = ysub_q;
      pal_d      = pal_q;
      hflip_d    = hflip_q;
      vflip_d    = vflip_q;
      code_d     = code_q;
      done_d     = done_q;
      overflow_d = overflow_q;
      if (bus.hinit_x) begin
         draw_d     = 1'b0;
         done_d     = 1'b0;
         overflow_d = 1'b0;
         index_d    = IW'(OBJ_CNT - 1);
         cnt_d      = '0;
         objAddr_d  = {IW'(OBJ_CNT - 1), 2'b00};
      end else begin
         case (state_q)
            READ: begin
               cnt_d = cnt_q + 1'b1;
               case (cnt_q)
                  3'd1:    yByte_d    = bus.obj_dout;
                  3'd2:    codeByte_d = bus.obj_dout;
                  3'd3:    attrByte_d = bus.obj_dout;
                  3'd4:    xByte_d    = bus.obj_dout;
                  default: ;
               endcase
               if (cnt_q < 3'd3)
                  objAddr_d = {index_q, 2'(cnt_q[1:0] + 2'd1)};
            end
            CHECK: begin
               if (hit && limitReached) begin
                  overflow_d = 1'b1;
               end else if (hit && !bus.busy) begin
                  draw_d  = 1'b1;
                  xpos_d  = xByte_q;
                  ysub_d  = dy[3:0];
                  pal_d   = attrByte_q[4:0];
                  hflip_d = attrByte_q[6];
                  vflip_d = attrByte_q[7];
                  code_d  = codeByte_q;
               end
            end
            DRAW: if (bus.busy) draw_d = 1'b0;
            NEXT: begin
               if (index_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  index_d   = index_q - 1'b1;
                  cnt_d     = '0;
                  objAddr_d = {index_q - 1'b1, 2'b00};
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.obj_addr = objAddr_q;
   assign bus.draw     = draw_q;
   assign bus.xpos     = xpos_q;
   assign bus.ysub     = ysub_q;
   assign bus.pal      = pal_q;
   assign bus.hflip    = hflip_q;
   assign bus.vflip    = vflip_q;
   assign bus.code     = code_q;
   assign bus.done     = done_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_jtpinpon_objscan.sv
// Testbench for jtpinpon_objscan: object RAM and drawer models, a table of single-object lines,
// then hand-written priority, restart, line-limit and reset-mid-draw sequences.
module tb_jtpinpon_objscan;
   localparam int BUSY_LEN = 17;
`ifdef JTPINPON_OBJSCAN_LIMIT_EN
   localparam int LIMIT_DRAWS = 8;
   localparam int LIMIT_OVF   = 1;
`else
   localparam int LIMIT_DRAWS = 12;
   localparam int LIMIT_OVF   = 0;
`endif

   typedef struct packed {
      logic [7:0] code;
      logic [7:0] xpos;
      logic [3:0] ysub;
      logic [4:0] pal;
      logic       hflip;
      logic       vflip;
   } draw_t;

   typedef struct {
      int         idx;
      logic [7:0] y, code, attr, x, vr;
      int         expHit;
      logic [3:0] expYsub;
      logic [4:0] expPal;
      logic       expHflip, expVflip;
   } vec_t;

   logic  clk  = 1'b0;
   logic  rst  = 1'b1;
   logic  cen2 = 1'b0;
   logic [7:0] mem [0:127];
   draw_t drawLog[$];
   draw_t riseSnap;
   int    busyCnt;
   int    drawCycles     = 0;
   int    busyViolations = 0;
   int    stabErrors     = 0;
   logic  drawPrev       = 1'b0;
   int    testsRun       = 0;
   int    testsFailed    = 0;

   jtpinpon_objscan_if bus();

   jtpinpon_objscan dut (
      .clk    (clk),
      .rst    (rst),
      .cen2_i (cen2),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // cen2 is high on every other clock edge
   always @(posedge clk) cen2 <= ~cen2;

   // Synchronous object RAM
   always @(posedge clk) if (cen2) bus.obj_dout <= mem[bus.obj_addr];

   // Drawer model: accepts draw while idle and stays busy for BUSY_LEN cen2 cycles
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.busy <= 1'b0;
         busyCnt  <= 0;
      end else if (cen2) begin
         if (bus.draw && !bus.busy) begin
            bus.busy <= 1'b1;
            busyCnt  <= BUSY_LEN - 1;
            drawLog.push_back(snap());
         end else if (bus.busy) begin
            if (busyCnt == 0) bus.busy <= 1'b0;
            else busyCnt <= busyCnt - 1;
         end
      end
   end

   // Protocol monitor: draw-high cycles, draw raised while busy, attribute stability
   always @(posedge clk) begin
      if (rst) begin
         drawPrev = 1'b0;
      end else if (cen2) begin
         if (bus.draw) drawCycles++;
         if (bus.draw && !drawPrev) begin
            if (bus.busy) busyViolations++;
            riseSnap = snap();
         end else if (bus.draw && drawPrev) begin
            if (snap() != riseSnap) stabErrors++;
         end
         drawPrev = bus.draw;
      end
   end

   function automatic draw_t snap();
      return '{code: bus.code, xpos: bus.xpos, ysub: bus.ysub, pal: bus.pal,
               hflip: bus.hflip, vflip: bus.vflip};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
   endtask

   task automatic writeObj(input int idx, input logic [7:0] y, code, attr, x);
      mem[idx*4 + 0] = y;
      mem[idx*4 + 1] = code;
      mem[idx*4 + 2] = attr;
      mem[idx*4 + 3] = x;
   endtask

   // Pulses hinit_x for exactly one cen2 edge and checks the restart state
   task automatic applyStimulus(input string name, input logic [7:0] vr);
      @(negedge clk);
      while (!cen2) @(negedge clk);
      bus.vrender = vr;
      bus.hinit_x = 1'b1;
      @(negedge clk);
      bus.hinit_x = 1'b0;
      checkOutput({name, " hinit clears done"}, bus.done, 1'b0);
      checkOutput({name, " hinit clears overflow"}, bus.overflow, 1'b0);
      checkOutput({name, " hinit addr"}, bus.obj_addr, 7'h7C);
      checkOutput({name, " hinit draw"}, bus.draw, 1'b0);
   endtask

   task automatic waitDone(input string name, input int maxClk);
      int n = 0;
      while (bus.done !== 1'b1 && n < maxClk) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, " done"}, bus.done, 1'b1);
   endtask

   task automatic waitLog(input string name, input int target, input int maxClk);
      int n = 0;
      while (drawLog.size() < target && n < maxClk) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, " draws reached"}, drawLog.size(), target);
   endtask

   initial begin
      vec_t  vecs[8];
      draw_t d;
      int    base, cyc0, n;

      vecs[0] = '{5,  8'h40, 8'h2A, 8'hC3, 8'h70, 8'h35, 1, 4'h5, 5'h03, 1'b1, 1'b1};
      vecs[1] = '{0,  8'h45, 8'h11, 8'h02, 8'h08, 8'h35, 1, 4'h0, 5'h02, 1'b0, 1'b0};
      vecs[2] = '{0,  8'h46, 8'h11, 8'h02, 8'h08, 8'h35, 0, 4'h0, 5'h00, 1'b0, 1'b0};
      vecs[3] = '{31, 8'h36, 8'hFF, 8'h5F, 8'hFF, 8'h35, 1, 4'hF, 5'h1F, 1'b1, 1'b0};
      vecs[4] = '{10, 8'h35, 8'h01, 8'h00, 8'h00, 8'h35, 0, 4'h0, 5'h00, 1'b0, 1'b0};
      vecs[5] = '{7,  8'h00, 8'h33, 8'h00, 8'h10, 8'hF0, 0, 4'h0, 5'h00, 1'b0, 1'b0};
      vecs[6] = '{20, 8'h05, 8'h80, 8'h80, 8'h01, 8'hF8, 1, 4'h3, 5'h00, 1'b0, 1'b1};
      vecs[7] = '{12, 8'hFF, 8'h5A, 8'h3F, 8'hC0, 8'hEF, 1, 4'h0, 5'h1F, 1'b0, 1'b0};

      bus.hinit_x = 1'b0;
      bus.vrender = 8'h00;
      clearMem();

      repeat (4) @(negedge clk);
      checkOutput("reset draw", bus.draw, 1'b0);
      checkOutput("reset done", bus.done, 1'b0);
      checkOutput("reset overflow", bus.overflow, 1'b0);
      checkOutput("reset obj_addr", bus.obj_addr, 7'h00);
      checkOutput("reset attrs", snap(), '0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("idle without hinit", drawLog.size(), 0);

      for (int i = 0; i < 8; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         clearMem();
         writeObj(vecs[i].idx, vecs[i].y, vecs[i].code, vecs[i].attr, vecs[i].x);
         base = drawLog.size();
         cyc0 = drawCycles;
         applyStimulus(nm, vecs[i].vr);
         waitDone(nm, 3000);
         checkOutput({nm, " draws"}, drawLog.size() - base, vecs[i].expHit);
         checkOutput({nm, " draw high cycles"}, drawCycles - cyc0, 2 * vecs[i].expHit);
         checkOutput({nm, " overflow"}, bus.overflow, 1'b0);
         if (vecs[i].expHit == 1 && drawLog.size() > base) begin
            d = drawLog[base];
            checkOutput({nm, " xpos"}, d.xpos, vecs[i].x);
            checkOutput({nm, " ysub"}, d.ysub, vecs[i].expYsub);
            checkOutput({nm, " pal"}, d.pal, vecs[i].expPal);
            checkOutput({nm, " hflip"}, d.hflip, vecs[i].expHflip);
            checkOutput({nm, " vflip"}, d.vflip, vecs[i].expVflip);
            checkOutput({nm, " code"}, d.code, vecs[i].code);
            checkOutput({nm, " outputs hold"}, bus.code, vecs[i].code);
         end
      end

      // Priority: higher index drawn first, second draw only after busy drops
      $display("[TB] priority sequence");
      clearMem();
      writeObj(3, 8'h40, 8'h03, 8'h00, 8'h33);
      writeObj(1, 8'h41, 8'h01, 8'h00, 8'h11);
      base = drawLog.size();
      applyStimulus("prio", 8'h35);
      waitDone("prio", 3000);
      checkOutput("prio draws", drawLog.size() - base, 2);
      if (drawLog.size() >= base + 2) begin
         checkOutput("prio first code", drawLog[base].code, 8'h03);
         checkOutput("prio first ysub", drawLog[base].ysub, 4'h5);
         checkOutput("prio second code", drawLog[base+1].code, 8'h01);
         checkOutput("prio second ysub", drawLog[base+1].ysub, 4'h4);
      end
      checkOutput("prio draw raised while busy", busyViolations, 0);

      // Restart during WAIT of the 2nd of 4 hits
      $display("[TB] restart sequence");
      clearMem();
      writeObj(30, 8'h40, 8'h30, 8'h00, 8'h01);
      writeObj(20, 8'h40, 8'h20, 8'h00, 8'h02);
      writeObj(10, 8'h40, 8'h10, 8'h00, 8'h03);
      writeObj(2,  8'h40, 8'h02, 8'h00, 8'h04);
      base = drawLog.size();
      applyStimulus("restart line1", 8'h35);
      waitLog("restart", base + 2, 3000);
      n = 0;
      while (bus.draw !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("restart in WAIT busy", bus.busy, 1'b1);
      applyStimulus("restart line2", 8'h35);
      waitDone("restart", 6000);
      checkOutput("restart total draws", drawLog.size() - base, 6);
      if (drawLog.size() >= base + 6) begin
         checkOutput("restart code a", drawLog[base+2].code, 8'h30);
         checkOutput("restart code b", drawLog[base+3].code, 8'h20);
         checkOutput("restart code c", drawLog[base+4].code, 8'h10);
         checkOutput("restart code d", drawLog[base+5].code, 8'h02);
      end
      checkOutput("restart draw raised while busy", busyViolations, 0);

      // Line limit: 12 hits at even indices 0..22
      $display("[TB] line limit sequence");
      clearMem();
      for (int k = 0; k < 12; k++) writeObj(2*k, 8'h40, 8'(2*k), 8'h00, 8'h50);
      base = drawLog.size();
      applyStimulus("limit", 8'h35);
      waitDone("limit", 8000);
      checkOutput("limit draws", drawLog.size() - base, LIMIT_DRAWS);
      checkOutput("limit overflow", bus.overflow, LIMIT_OVF);
      if (drawLog.size() >= base + LIMIT_DRAWS) begin
         for (int j = 0; j < LIMIT_DRAWS; j++)
            checkOutput($sformatf("limit order %0d", j), drawLog[base+j].code, 8'(22 - 2*j));
      end

      // Asynchronous reset while draw is high
      $display("[TB] reset mid-draw sequence");
      clearMem();
      writeObj(5, 8'h40, 8'h2A, 8'hC3, 8'h70);
      applyStimulus("rstdraw", 8'h35);
      n = 0;
      while (bus.draw !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rstdraw draw seen", bus.draw, 1'b1);
      #1 rst = 1'b1;
      #1;
      checkOutput("rstdraw draw", bus.draw, 1'b0);
      checkOutput("rstdraw attrs", snap(), '0);
      checkOutput("rstdraw obj_addr", bus.obj_addr, 7'h00);
      checkOutput("rstdraw done", bus.done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      base = drawLog.size();
      cyc0 = drawCycles;
      repeat (400) @(negedge clk);
      checkOutput("rstdraw no requests", drawLog.size() - base, 0);
      checkOutput("rstdraw no draw cycles", drawCycles - cyc0, 0);
      checkOutput("rstdraw idle addr", bus.obj_addr, 7'h00);
      applyStimulus("rstdraw resume", 8'h35);
      waitDone("rstdraw resume", 3000);
      checkOutput("rstdraw resume draws", drawLog.size() - base, 1);

      checkOutput("draw raised while busy", busyViolations, 0);
      checkOutput("attributes stable during draw", stabErrors, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
